// File: rtl/input_password_pkg.sv
// Shared keypad constants and the column/row to hex-digit key map.
package input_password_pkg;

  localparam logic [3:0] COL_IDLE_ROW = 4'hF;
  localparam logic [3:0] COL_RESET    = 4'b0111;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } key_t;

  // valid only when exactly one column and exactly one row are pulled low
  function automatic key_t decode_key(input logic [3:0] col, input logic [3:0] row);
    key_t       k;
    logic [1:0] c;
    logic [1:0] r;
    logic       c_ok;
    logic       r_ok;
    k    = '0;
    c    = 2'd0;
    r    = 2'd0;
    c_ok = 1'b1;
    r_ok = 1'b1;
    case (col)
      4'b0111: c = 2'd0;
      4'b1011: c = 2'd1;
      4'b1101: c = 2'd2;
      4'b1110: c = 2'd3;
      default: c_ok = 1'b0;
    endcase
    case (row)
      4'b0111: r = 2'd0;
      4'b1011: r = 2'd1;
      4'b1101: r = 2'd2;
      4'b1110: r = 2'd3;
      default: r_ok = 1'b0;
    endcase
    case ({c, r})
      4'h0: k.digit = 4'h1;
      4'h1: k.digit = 4'h4;
      4'h2: k.digit = 4'h7;
      4'h3: k.digit = 4'h0;
      4'h4: k.digit = 4'h2;
      4'h5: k.digit = 4'h5;
      4'h6: k.digit = 4'h8;
      4'h7: k.digit = 4'hF;
      4'h8: k.digit = 4'h3;
      4'h9: k.digit = 4'h6;
      4'hA: k.digit = 4'h9;
      4'hB: k.digit = 4'hE;
      4'hC: k.digit = 4'hA;
      4'hD: k.digit = 4'hB;
      4'hE: k.digit = 4'hC;
      default: k.digit = 4'hD;
    endcase
    k.valid = c_ok && r_ok;
    return k;
  endfunction

endpackage

// File: rtl/input_password_keypad_scanner.sv
// Column scan with per-column dwell, scan freeze while any row is low,
// and a one-shot key strobe on the first sample of a single-key press.
module keypad_scanner
  import input_password_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       key_stb_o,
  output logic [3:0] digit_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [3:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle_q, idle_d;
  key_t             key;

  always_comb begin
    col_d  = col_q;
    cnt_d  = cnt_q;
    idle_d = (row_i == COL_IDLE_ROW);
    // any low row freezes the scan so the held key keeps its column
    if (row_i == COL_IDLE_ROW) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        col_d = {col_q[0], col_q[3:1]};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q  <= COL_RESET;
      cnt_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      col_q  <= col_d;
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
    end
  end

  assign key       = decode_key(col_q, row_i);
  assign key_stb_o = idle_q && key.valid;
  assign digit_o   = key.digit;
  assign col_o     = col_q;

endmodule

// File: rtl/input_password.sv
// Keypad entry front end: scans the keypad and keeps the last four digits
// pressed as a 16-bit code, newest digit in the low nibble.
module input_password
  import input_password_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] code
);

  logic        key_stb;
  logic [3:0]  digit;
  logic [15:0] code_q, code_d;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk_i     (clk),
    .rst_ni    (rst),
    .row_i     (row),
    .col_o     (col),
    .key_stb_o (key_stb),
    .digit_o   (digit)
  );

  always_comb begin
    code_d = code_q;
    if (key_stb) code_d = {code_q[11:0], digit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) code_q <= 16'h0000;
    else      code_q <= code_d;
  end

  assign code = code_q;

endmodule

// File: tb/tb_input_password.sv
// Directed and randomized checks of input_password against a digit-level
// keypad model; a second instance with SCAN_DIV=4 checks the dwell time.
module tb_input_password;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, row4;
  logic [3:0]  col, col4;
  logic [15:0] code, code4;

  always #5 clk = ~clk;

  input_password #(.SCAN_DIV(1)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .code(code)
  );

  input_password #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .row(row4), .col(col4), .code(code4)
  );

  int compared   = 0;
  int mismatched = 0;

  // keymap[column position][row position]; position 0 is the MSB line
  int keymap [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

  int          m_p, m_dwell, m_p4, m_dwell4;
  bit          m_idle;
  logic [15:0] m_code;

  logic [3:0]  prev_col4;
  int          n;
  int          sel;
  logic [3:0]  rnd_row;
  logic [3:0]  one_hot;

  function automatic logic [3:0] col_of(input int p);
    logic [3:0] msb;
    msb = 4'b1000;
    return ~(msb >> p);
  endfunction

  task automatic model_reset();
    m_p = 0; m_dwell = 0; m_p4 = 0; m_dwell4 = 0;
    m_idle = 1'b1; m_code = 16'h0000;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".col"}, {12'h0, col}, {12'h0, col_of(m_p)});
    chk({tag, ".code"}, code, m_code);
    chk({tag, ".col4"}, {12'h0, col4}, {12'h0, col_of(m_p4)});
    chk({tag, ".code4"}, code4, 16'h0000);
  endtask

  // drive one row sample, clock it, advance the model, compare
  task automatic step(input logic [3:0] r, input string tag);
    int lows;
    int lowbit;
    row = r;
    @(posedge clk);
    #1;
    lows = 0;
    lowbit = 0;
    for (int b = 0; b < 4; b++) if (r[b] == 1'b0) begin lows++; lowbit = b; end
    if (m_idle && lows == 1)
      m_code = {m_code[11:0], 4'(keymap[m_p][3 - lowbit])};
    if (r == 4'hF) begin
      m_dwell++;
      if (m_dwell == 1) begin m_dwell = 0; m_p = (m_p + 1) % 4; end
    end
    m_dwell4++;
    if (m_dwell4 == 4) begin m_dwell4 = 0; m_p4 = (m_p4 + 1) % 4; end
    m_idle = (r == 4'hF);
    check_all(tag);
  endtask

  task automatic align(input int c);
    int k;
    k = 0;
    while (m_p != c && k < 8) begin step(4'hF, "align"); k++; end
    chk("align.col", {12'h0, col}, {12'h0, col_of(c)});
  endtask

  task automatic press_key(input int key);
    int c, ri;
    logic [3:0] r;
    logic [3:0] lsb;
    c = 0; ri = 0; lsb = 4'b0001;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (keymap[i][j] == key) begin c = i; ri = j; end
    r = ~(lsb << (3 - ri));
    step(4'hF, "gap");
    step(4'hF, "gap");
    align(c);
    step(r, "press");
    step(4'hF, "release");
  endtask

  initial begin
    rst = 1'b0; row = 4'hF; row4 = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    chk("reset.code_const", code, 16'h0000);
    rst = 1'b1;

    repeat (4) step(4'hF, "scan");
    chk("scan.wrap", {12'h0, col}, 16'h0007);

    step(4'b0111, "press1");
    chk("press1.code", code, 16'h0001);
    chk("press1.col_hold", {12'h0, col}, 16'h0007);
    step(4'hF, "release1");

    press_key(1); press_key(2); press_key(3); press_key(10);
    chk("entry.123A", code, 16'h123A);
    press_key(0);
    chk("overflow.23A0", code, 16'h23A0);

    step(4'hF, "gap"); step(4'hF, "gap");
    align(3);
    repeat (6) begin
      step(4'b1011, "holdB");
      chk("holdB.col", {12'h0, col}, 16'h000E);
    end
    chk("holdB.once", code, 16'h3A0B);
    step(4'hF, "holdB.rel");
    chk("holdB.resume", {12'h0, col}, 16'h0007);

    repeat (3) step(4'b0011, "multi");
    chk("multi.code", code, 16'h3A0B);
    step(4'hF, "multi.rel");

    one_hot = 4'b0001;
    repeat (300) begin
      sel = $urandom_range(0, 99);
      if (sel < 50)      rnd_row = 4'hF;
      else if (sel < 85) rnd_row = ~(one_hot << $urandom_range(0, 3));
      else               rnd_row = 4'($urandom_range(0, 15));
      step(rnd_row, "rand");
    end

    step(4'hF, "gap");
    press_key(1); press_key(2); press_key(3); press_key(10);
    chk("reentry.123A", code, 16'h123A);

    #2 rst = 1'b0;
    #1;
    chk("async.code", code, 16'h0000);
    chk("async.col", {12'h0, col}, 16'h0007);
    chk("async.col4", {12'h0, col4}, 16'h0007);
    model_reset();
    row = 4'b0111;
    @(posedge clk);
    #1;
    check_all("in_reset");
    rst = 1'b1;
    step(4'b0111, "held_thru_reset");
    chk("held_thru_reset.code", code, 16'h0001);
    step(4'b0111, "held_again");
    chk("held_again.code", code, 16'h0001);
    step(4'hF, "held.rel");

    prev_col4 = col4; n = 0;
    while (col4 == prev_col4 && n < 10) begin step(4'hF, "dwell.sync"); n++; end
    prev_col4 = col4; n = 0;
    while (col4 == prev_col4 && n < 10) begin step(4'hF, "dwell.run"); n++; end
    chk("dwell4.len", 16'(n), 16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
